bus_fifo_port: RTL and testbench

Memory-mapped byte-stream port that acts as a responder on the CPU's 8-bit data / 16-bit address bus. It sits behind the top-level address decoder alongside ROM, and bridges CPU bus reads/writes to a pair of byte FIFOs: a TX FIFO, which the CPU fills and an outgoing valid/ready stream drains, and an RX FIFO, which an incoming valid/ready stream fills and the CPU drains. It also raises a level interrupt request for the CPU.

---
 rtl/bus_fifo_port.sv | 162 ++++++++++++++++
 tb/tb_bus_fifo_port.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_port.sv
// Memory-mapped byte-stream port: bridges CPU bus accesses to a TX byte FIFO
// (CPU fills, outgoing stream drains) and an RX byte FIFO (incoming stream
// fills, CPU drains), with sticky error flags and a level interrupt request.
module bus_fifo_port #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipSelect,
  input  logic       read,
  input  logic       write,
  input  logic [1:0] address,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  output logic       txValid,
  output logic [7:0] txData,
  input  logic       txReady,
  input  logic       rxValid,
  input  logic [7:0] rxData,
  output logic       rxReady,
  output logic       irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [3:0]    tx_count, rx_count;
  logic          rx_ie, tx_ie, tx_overflow, rx_underflow;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       wr_access, rd_access;
  logic       data_wr, data_rd, status_wr, ctrl_wr, flush;
  logic       tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_miss;
  logic [3:0] tx_count_next, rx_count_next;
  logic       rx_ie_next, tx_ie_next, irq_next;
  logic [7:0] read_data;

  // Start-of-cycle FIFO flags and stream-side outputs
  assign tx_empty = (tx_count == 4'd0);
  assign tx_full  = (tx_count == FULL_COUNT);
  assign rx_empty = (rx_count == 4'd0);
  assign rx_full  = (rx_count == FULL_COUNT);

  assign txValid = !tx_empty;
  assign txData  = tx_empty ? 8'h00 : tx_mem[tx_rd];
  assign rxReady = !rx_full;

  // A simultaneous read and write performs only the write
  assign wr_access = chipSelect && write;
  assign rd_access = chipSelect && read && !write;

  assign data_wr   = wr_access && (address == ADDR_DATA);
  assign data_rd   = rd_access && (address == ADDR_DATA);
  assign status_wr = wr_access && (address == ADDR_STATUS);
  assign ctrl_wr   = wr_access && (address == ADDR_CONTROL);
  assign flush     = ctrl_wr && dataIn[7];

  // A full FIFO refuses a push even when it is popped in the same cycle
  assign tx_push = data_wr && !tx_full;
  assign tx_drop = data_wr && tx_full;
  assign tx_pop  = txValid && txReady;
  assign rx_push = rxValid && rxReady;
  assign rx_pop  = data_rd && !rx_empty;
  assign rx_miss = data_rd && rx_empty;

  // Post-update counts and enables, used to compute the next interrupt level
  always_comb begin
    tx_count_next = tx_count;
    rx_count_next = rx_count;
    rx_ie_next    = rx_ie;
    tx_ie_next    = tx_ie;
    if (flush) begin
      tx_count_next = 4'd0;
      rx_count_next = 4'd0;
    end else begin
      tx_count_next = tx_count + {3'b000, tx_push} - {3'b000, tx_pop};
      rx_count_next = rx_count + {3'b000, rx_push} - {3'b000, rx_pop};
    end
    if (ctrl_wr) begin
      rx_ie_next = dataIn[0];
      tx_ie_next = dataIn[1];
    end
    irq_next = (rx_ie_next && (rx_count_next != 4'd0)) ||
               (tx_ie_next && (tx_count_next == 4'd0));
  end

  // Read mux over start-of-cycle state; zero whenever no selected read happens
  always_comb begin
    read_data = 8'h00;
    if (rd_access) begin
      case (address)
        ADDR_DATA:    read_data = rx_empty ? 8'h00 : rx_mem[rx_rd];
        ADDR_STATUS:  read_data = {1'b0, irq, rx_underflow, tx_overflow,
                                   tx_full, tx_empty, rx_full, rx_empty};
        ADDR_CONTROL: read_data = {6'b000000, tx_ie, rx_ie};
        ADDR_COUNT:   read_data = {tx_count, rx_count};
        default:      read_data = 8'h00;
      endcase
    end
  end

  // FIFO storage; a flush discards any same-cycle stream transfer
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (tx_push) tx_mem[tx_wr] <= dataIn;
      if (rx_push) rx_mem[rx_wr] <= rxData;
    end
  end

  // Pointers, counts, flags, enables, registered read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd        <= '0;
      tx_wr        <= '0;
      rx_rd        <= '0;
      rx_wr        <= '0;
      tx_count     <= 4'd0;
      rx_count     <= 4'd0;
      rx_ie        <= 1'b0;
      tx_ie        <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      dataOut      <= 8'h00;
      irq          <= 1'b0;
    end else begin
      if (flush) begin
        tx_rd <= '0;
        tx_wr <= '0;
        rx_rd <= '0;
        rx_wr <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + AW'(1);
        if (tx_pop)  tx_rd <= tx_rd + AW'(1);
        if (rx_push) rx_wr <= rx_wr + AW'(1);
        if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      end
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
      rx_ie    <= rx_ie_next;
      tx_ie    <= tx_ie_next;
      if (tx_drop)
        tx_overflow <= 1'b1;
      else if (status_wr && dataIn[4])
        tx_overflow <= 1'b0;
      if (rx_miss)
        rx_underflow <= 1'b1;
      else if (status_wr && dataIn[5])
        rx_underflow <= 1'b0;
      dataOut <= read_data;
      irq     <= irq_next;
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Self-checking bench for bus_fifo_port: directed register-map scenarios and
// randomized traffic, compared each cycle against a queue-based reference model.
module tb_bus_fifo_port;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, chipSelect, read, write;
  logic [1:0] address;
  logic [7:0] dataIn, dataOut;
  logic       txValid, txReady, rxValid, rxReady, irq;
  logic [7:0] txData, rxData;

  int checks = 0;
  int errors = 0;
  logic sink_ready = 1'b0;

  // Reference model state: plain byte queues plus flag bits
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic m_rx_ie, m_tx_ie, m_tx_ov, m_rx_un, m_irq;
  logic [7:0] m_dout;

  bus_fifo_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipSelect(chipSelect), .read(read),
    .write(write), .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .txValid(txValid), .txData(txData), .txReady(txReady),
    .rxValid(rxValid), .rxData(rxData), .rxReady(rxReady), .irq(irq)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Return the reference model to its reset state
  task automatic modelReset();
    txq.delete();
    rxq.delete();
    m_rx_ie = 0; m_tx_ie = 0; m_tx_ov = 0; m_rx_un = 0; m_irq = 0;
    m_dout = 8'h00;
  endtask

  // Advance the model by one clock edge using the register-map rules
  task automatic modelStep(input logic rst, cs, rd, wr, input logic [1:0] a,
                           input logic [7:0] d, input logic txr, rxv,
                           input logic [7:0] rxd);
    int txn, rxn;
    logic wa, ra, fl, txpop, rxpush;
    logic [7:0] nd;
    if (rst) begin
      modelReset();
      return;
    end
    txn = txq.size();
    rxn = rxq.size();
    wa = cs && wr;
    ra = cs && rd && !wr;
    nd = 8'h00;
    if (ra) begin
      case (a)
        2'd0: if (rxn > 0) nd = rxq[0]; else m_rx_un = 1;
        2'd1: nd = {1'b0, m_irq, m_rx_un, m_tx_ov, txn == DEPTH, txn == 0,
                    rxn == DEPTH, rxn == 0};
        2'd2: nd = {6'd0, m_tx_ie, m_rx_ie};
        default: nd = {4'(txn), 4'(rxn)};
      endcase
    end
    fl = wa && (a == 2'd2) && d[7];
    txpop = (txn > 0) && txr;
    rxpush = rxv && (rxn < DEPTH);
    if (fl) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (txpop) void'(txq.pop_front());
      if (wa && a == 2'd0) begin
        if (txn < DEPTH) txq.push_back(d); else m_tx_ov = 1;
      end
      if (ra && a == 2'd0 && rxn > 0) void'(rxq.pop_front());
      if (rxpush) rxq.push_back(rxd);
    end
    if (wa && a == 2'd1) begin
      if (d[4]) m_tx_ov = 0;
      if (d[5]) m_rx_un = 0;
    end
    if (wa && a == 2'd2) begin
      m_rx_ie = d[0];
      m_tx_ie = d[1];
    end
    m_irq = (m_rx_ie && rxq.size() > 0) || (m_tx_ie && txq.size() == 0);
    m_dout = nd;
  endtask

  // Drive one cycle of inputs, check all outputs against the model, clock it
  task automatic applyStimulus(input logic rst, cs, rd, wr, input logic [1:0] a,
                               input logic [7:0] d, input logic txr, rxv,
                               input logic [7:0] rxd);
    reset = rst; chipSelect = cs; read = rd; write = wr; address = a;
    dataIn = d; txReady = txr; rxValid = rxv; rxData = rxd;
    #1;
    checkOutput("dataOut", dataOut, m_dout);
    checkOutput("irq", {7'd0, irq}, {7'd0, m_irq});
    checkOutput("txValid", {7'd0, txValid}, {7'd0, logic'(txq.size() > 0)});
    checkOutput("txData", txData, (txq.size() > 0) ? txq[0] : 8'h00);
    checkOutput("rxReady", {7'd0, rxReady}, {7'd0, logic'(rxq.size() < DEPTH)});
    modelStep(rst, cs, rd, wr, a, d, txr, rxv, rxd);
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(0, 1, 0, 1, a, d, sink_ready, 0, 8'h00);
  endtask

  task automatic busRead(input logic [1:0] a);
    applyStimulus(0, 1, 1, 0, a, 8'h00, sink_ready, 0, 8'h00);
  endtask

  task automatic streamIn(input logic [7:0] b);
    applyStimulus(0, 0, 0, 0, 2'd0, 8'h00, sink_ready, 1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 2'd0, 8'h00, sink_ready, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] a;
    reset = 1; chipSelect = 0; read = 0; write = 0; address = 0;
    dataIn = 0; txReady = 0; rxValid = 0; rxData = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state
    busRead(2'd1);
    checkOutput("status_after_reset", dataOut, 8'h05);
    busRead(2'd3);
    checkOutput("count_after_reset", dataOut, 8'h00);
    checkOutput("rxReady_after_reset", {7'd0, rxReady}, 8'h01);
    checkOutput("txValid_after_reset", {7'd0, txValid}, 8'h00);

    // Three TX bytes, then drain
    sink_ready = 0;
    busWrite(2'd0, 8'h11); busWrite(2'd0, 8'h22); busWrite(2'd0, 8'h33);
    busRead(2'd3);
    checkOutput("count_tx3", dataOut, 8'h30);
    checkOutput("txData_head", txData, 8'h11);
    sink_ready = 1;
    idle(3);
    checkOutput("txValid_drained", {7'd0, txValid}, 8'h00);

    // TX overflow and clear
    sink_ready = 0;
    for (int i = 0; i < 9; i++) busWrite(2'd0, 8'hA0 + 8'(i));
    busRead(2'd1);
    checkOutput("status_tx_overflow", dataOut, 8'h19);
    busWrite(2'd1, 8'h10);
    busRead(2'd1);
    checkOutput("status_ov_cleared", dataOut, 8'h09);
    sink_ready = 1;
    idle(9);
    checkOutput("txValid_after_drain8", {7'd0, txValid}, 8'h00);

    // RX stream and reads including underflow
    streamIn(8'h5A); streamIn(8'hC3);
    busRead(2'd3);
    checkOutput("count_rx2", dataOut, 8'h02);
    busRead(2'd0);
    checkOutput("rx_first", dataOut, 8'h5A);
    busRead(2'd0);
    checkOutput("rx_second", dataOut, 8'hC3);
    busRead(2'd0);
    checkOutput("rx_empty_read", dataOut, 8'h00);
    busRead(2'd1);
    checkOutput("status_underflow", dataOut, 8'h25);

    // Interrupt enables
    busWrite(2'd2, 8'h01);
    streamIn(8'h77);
    checkOutput("irq_rx_rise", {7'd0, irq}, 8'h01);
    busRead(2'd0);
    checkOutput("irq_rx_fall", {7'd0, irq}, 8'h00);
    busWrite(2'd2, 8'h02);
    checkOutput("irq_tx_empty", {7'd0, irq}, 8'h01);

    // Full RX with simultaneous pop and refused push, then flush
    for (int i = 0; i < DEPTH; i++) streamIn(8'h40 + 8'(i));
    checkOutput("rxReady_full", {7'd0, rxReady}, 8'h00);
    applyStimulus(0, 1, 1, 0, 2'd0, 8'h00, sink_ready, 1, 8'hEE);
    checkOutput("pop_at_full", dataOut, 8'h40);
    busRead(2'd3);
    checkOutput("count_rx7", dataOut, 8'h07);
    busWrite(2'd2, 8'h80);
    busRead(2'd3);
    checkOutput("count_flushed", dataOut, 8'h00);
    checkOutput("rxReady_flushed", {7'd0, rxReady}, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd2 && $urandom_range(0, 7) != 0) d[7] = 1'b0;
      applyStimulus($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2) == 0, a, d, 1'($urandom),
                    1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
